// File: rtl/cpu_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: funct codes,
// sequencer states and small operand helpers.
package cpu_muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } state_e;

    // Even funct codes in the MULT/DIV group are the signed variants.
    function automatic logic is_signed_op(input logic [5:0] funct);
        return ~funct[0];
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/cpu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and record the quotient bit.
module cpu_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [32:0] trial;
    logic        fits;

    assign shifted = {rem_i, quo_i[31]};
    assign trial   = shifted - {1'b0, divisor_i};
    assign fits    = ~trial[32];

    assign rem_o = fits ? trial[31:0] : shifted[31:0];
    assign quo_o = {quo_i[30:0], fits};

endmodule

// File: rtl/cpu_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 32-step restoring
// divide, MF/MT register access and flush, with issue back-pressure.
module cpu_muldiv_ctrl
    import cpu_muldiv_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_W = (MUL_LAT > DIV_STEPS) ? $clog2(MUL_LAT) : $clog2(DIV_STEPS);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [31:0]        hi_q,        hi_d;
    logic [31:0]        lo_q,        lo_d;
    logic [31:0]        op_a_q,      op_a_d;
    logic [31:0]        op_b_q,      op_b_d;
    logic               signed_q,    signed_d;
    logic [31:0]        rem_q,       rem_d;
    logic [31:0]        quo_q,       quo_d;
    logic [31:0]        dvsr_q,      dvsr_d;
    logic               neg_quo_q,   neg_quo_d;
    logic               neg_rem_q,   neg_rem_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_data_q,  res_data_d;

    logic               accept;
    logic [31:0]        step_rem;
    logic [31:0]        step_quo;
    logic [63:0]        mul_a_ext;
    logic [63:0]        mul_b_ext;
    logic [63:0]        product;
    logic [31:0]        quo_fixed;
    logic [31:0]        rem_fixed;

    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid & req_ready & ~flush;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

    cpu_div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // The low 64 bits of a sign-extended product equal the signed product.
    assign mul_a_ext = signed_q ? {{32{op_a_q[31]}}, op_a_q} : {32'd0, op_a_q};
    assign mul_b_ext = signed_q ? {{32{op_b_q[31]}}, op_b_q} : {32'd0, op_b_q};
    assign product   = mul_a_ext * mul_b_ext;

    assign quo_fixed = neg_quo_q ? neg32(quo_q) : quo_q;
    assign rem_fixed = neg_rem_q ? neg32(rem_q) : rem_q;

    always_comb begin
        // NOTE: every _d gets a hold value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        signed_d    = signed_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (req_funct)
                        FN_MTHI: hi_d = req_a;
                        FN_MTLO: lo_d = req_a;
                        FN_MFHI: begin
                            res_valid_d = 1'b1;
                            res_data_d  = hi_q;
                        end
                        FN_MFLO: begin
                            res_valid_d = 1'b1;
                            res_data_d  = lo_q;
                        end
                        FN_MULT, FN_MULTU: begin
                            op_a_d   = req_a;
                            op_b_d   = req_b;
                            signed_d = is_signed_op(req_funct);
                            cnt_d    = CNT_W'(MUL_LAT - 1);
                            state_d  = MUL;
                        end
                        FN_DIV, FN_DIVU: begin
                            op_a_d    = req_a;
                            op_b_d    = req_b;
                            signed_d  = is_signed_op(req_funct);
                            rem_d     = 32'd0;
                            quo_d     = is_signed_op(req_funct) ? abs32(req_a) : req_a;
                            dvsr_d    = is_signed_op(req_funct) ? abs32(req_b) : req_b;
                            neg_quo_d = is_signed_op(req_funct) & (req_a[31] ^ req_b[31]);
                            neg_rem_d = is_signed_op(req_funct) & req_a[31];
                            cnt_d     = CNT_W'(DIV_STEPS - 1);
                            state_d   = DIV_ITER;
                        end
                        default: ;
                    endcase
                end
            end

            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = product;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DIV_ITER: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) state_d = DIV_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end

            DIV_FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    // Divide by zero leaves all-ones quotient and the raw dividend.
                    if (op_b_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = op_a_q;
                    end else begin
                        lo_d = quo_fixed;
                        hi_d = rem_fixed;
                    end
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            signed_q    <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            signed_q    <= signed_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

// File: tb/tb_cpu_muldiv_ctrl.sv
// Scoreboard bench for cpu_muldiv_ctrl: an arithmetic HI/LO model predicts MF
// results and register state; a monitor checks every res_valid pulse.
module tb_cpu_muldiv_ctrl;
    import cpu_muldiv_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        res_valid;
    logic [31:0] res_data;
    logic        busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] exp_q[$];

    cpu_muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_STEPS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_funct (req_funct),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural effect of one accepted op.
    task automatic model_apply(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        case (f)
            FN_MFHI: exp_q.push_back(m_hi);
            FN_MFLO: exp_q.push_back(m_lo);
            FN_MTHI: m_hi = a;
            FN_MTLO: m_lo = a;
            FN_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            FN_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            FN_DIV: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = $signed(a) / $signed(b);
                    m_hi = $signed(a) % $signed(b);
                end
            end
            FN_DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit apply);
        int waited = 0;
        req_valid = 1'b1;
        req_funct = f;
        req_a     = a;
        req_b     = b;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("issue_timeout", 64'(waited), 64'd0);
        end else begin
            if (apply) model_apply(f, a, b);
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_funct = 6'd0;
    endtask

    task automatic measure_busy(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n), 64'(exp_cycles));
        check({name, "_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic check_regs(input string name);
        wait_idle();
        check({name, "_hi"}, 64'(hi_o), 64'(m_hi));
        check({name, "_lo"}, 64'(lo_o), 64'(m_lo));
    endtask

    task automatic flush_now();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] rand_funct();
        logic [5:0] fl[10] = '{FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT,
                               FN_MULTU, FN_DIV, FN_DIVU, 6'h1C, 6'h00};
        int k = $urandom_range(0, 10);
        if (k == 10) return 6'($urandom);
        return fl[k];
    endfunction

    // Monitor: every res_valid pulse must match the oldest predicted MF result.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL res_unexpected: got res_valid data %h expected no result", res_data);
            end else begin
                check("mf_data", 64'(res_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_funct = 6'd0;
        req_a = 32'd0;
        req_b = 32'd0;
        flush = 1'b0;
        #12;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiply latency and the MF stall behind a busy multiply.
        issue(FN_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1);
        check("mul_busy_now", 64'(req_ready), 64'd0);
        measure_busy("mul_busy_cycles", MUL_LAT);
        check_regs("mult");
        issue(FN_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue(FN_MFHI, 32'd0, 32'd0, 1'b1);
        issue(FN_MFLO, 32'd0, 32'd0, 1'b1);

        // Divide latency and the corner cases.
        issue(FN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        measure_busy("div_busy_cycles", DIV_LAT);
        check_regs("div_neg");
        issue(FN_DIVU, 32'd100, 32'd7, 1'b1);
        check_regs("divu");
        issue(FN_DIVU, 32'h1234_5678, 32'd0, 1'b1);
        measure_busy("divz_busy_cycles", DIV_LAT);
        check_regs("divu_zero");
        issue(FN_DIV, 32'hF000_0000, 32'd0, 1'b1);
        check_regs("div_zero_neg");
        issue(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_regs("div_ovf");

        // MT then MF back to back, and an unknown funct.
        issue(FN_MTLO, 32'hCAFE_BABE, 32'd0, 1'b1);
        issue(FN_MFLO, 32'd0, 32'd0, 1'b1);
        issue(6'h1C, 32'hDEAD_BEEF, 32'h1, 1'b1);
        check("unknown_busy", 64'(busy), 64'd0);
        check_regs("unknown");

        // Flush mid-divide, at multiply commit, at divide fix, and in idle.
        issue(FN_MTHI, 32'h1111_1111, 32'd0, 1'b1);
        issue(FN_MTLO, 32'h1111_1111, 32'd0, 1'b1);
        issue(FN_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush_now();
        check("flush_div_busy", 64'(busy), 64'd0);
        check_regs("flush_div");
        issue(FN_MULT, 32'd5, 32'd6, 1'b0);
        repeat (MUL_LAT - 1) @(negedge clk);
        flush_now();
        check("flush_mulcommit_busy", 64'(busy), 64'd0);
        check_regs("flush_mulcommit");
        issue(FN_DIVU, 32'd77, 32'd5, 1'b0);
        repeat (DIV_LAT - 1) @(negedge clk);
        flush_now();
        check_regs("flush_divfix");
        req_valid = 1'b1;
        req_funct = FN_MTHI;
        req_a = 32'h0BAD_F00D;
        flush_now();
        req_funct = FN_MFHI;
        flush_now();
        req_valid = 1'b0;
        @(negedge clk);
        check_regs("flush_idle");

        // Randomised traffic against the model.
        for (int i = 0; i < 60; i++) begin
            issue(rand_funct(), rand_operand(), rand_operand(), 1'b1);
            if (i % 6 == 5) check_regs("rand");
        end
        check_regs("rand_end");

        // Asynchronous reset in the middle of a multiply.
        issue(FN_MULT, 32'h7, 32'h9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        exp_q.delete();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd1);
        check("midrst_hi", 64'(hi_o), 64'd0);
        check("midrst_lo", 64'(lo_o), 64'd0);
        check("midrst_res", {31'd0, res_valid, res_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(FN_MFLO, 32'd0, 32'd0, 1'b1);
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_muldiv_ctrl.md
Name: cpu_muldiv_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide resource.
- Takes R-format mul-class ops (MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU) from the issue stage after decode.
- Owns the HI/LO registers and runs a fixed-latency multiply and a 32-step iterative divide.
- Back-pressures issue through a valid/ready handshake, supplies MFHI/MFLO read data, and supports pipeline flush on exceptions.

Parameters:
- MUL_LAT, 3, multiply occupancy in cycles (>=1).
- DIV_STEPS, 32, divide iteration count; fixed at 32, listed only for benches.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  issue presents a mul-class op.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_funct  in  6  instruction funct field.
- req_a  in  32  rs value.
- req_b  in  32  rt value.
- flush  in  1  cancel in-flight op and any same-cycle request.
- res_valid  out  1  one-cycle pulse carrying MFHI/MFLO data.
- res_data  out  32  MF read data.
- busy  out  1  state != IDLE.
- hi_o  out  32  current HI (debug/commit view).
- lo_o  out  32  current LO (debug/commit view).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, HI=LO=0, res_valid=0, res_data=0, counter=0, req_ready=1, busy=0.
- Accept condition: req_valid & req_ready & !flush at a clock edge. req_ready is combinational (state==IDLE).
- Funct codes:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - Any other funct is accepted and ignored: no state change, no res_valid.
- MTHI / MTLO: HI or LO <= req_a at the accept edge; visible on hi_o/lo_o in the next cycle. Stays IDLE.
- MFHI / MFLO: at the accept edge, res_data <= HI or LO and res_valid <= 1; the pulse lasts exactly one cycle. Stays IDLE.
  - MF accepted in the cycle right after an MT returns the newly written value.
- Multiply (MULT / MULTU):
  - Operands are latched at accept; state=MUL, cnt=MUL_LAT-1.
  - Each MUL cycle: if cnt==0, {HI,LO} <= 64-bit product (signed or unsigned) and state -> IDLE; else cnt--.
  - With accept in cycle N: occupies cycles N+1..N+MUL_LAT, HI/LO update at the end of N+MUL_LAT, req_ready returns high in N+MUL_LAT+1.
- Divide (DIV / DIVU):
  - At accept: latch |a| and |b| (signed) or raw values (unsigned), plus the sign flags. state=DIV_ITER, cnt=31.
  - DIV_ITER: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). Leave at cnt==0 for DIV_FIX.
  - DIV_FIX: apply signs (quotient negated if the operand signs differ, remainder takes the dividend's sign), commit LO=quotient and HI=remainder, then -> IDLE.
  - With accept in cycle N: HI/LO update at the end of N+33, ready in N+34.
  - Divisor zero: same latency, LO=0xFFFFFFFF, HI=req_a (signed or unsigned alike).
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Ops issued while busy: every request, MF/MT included, stalls via req_ready=0. This gives in-order HI/LO hazard safety.
- flush:
  - In MUL or DIV: state -> IDLE at the next edge, HI/LO unchanged (commit is atomic at completion), req_ready high in the following cycle.
  - In IDLE: the same-cycle request is dropped. A res_valid already asserted is not retracted.
  - flush coincident with the commit cycle: flush wins, no commit.
- Reset mid-operation: immediate return to reset values; partial results are discarded.

Decomposition:
- Shared package cpu_muldiv_pkg:
  - funct localparams (FN_MFHI … FN_DIVU).
  - State enum IDLE / MUL / DIV_ITER / DIV_FIX, 2 bits.
  - is_signed_op helper (funct[0]==0).
- One sub-module cpu_div_step: combinational single restoring step.
  - Inputs: rem[31:0], quo[31:0], divisor[31:0].
  - Outputs: next rem, next quo.
  - Instantiated once and iterated by the controller.

Test Plan:
- MULT a=0xFFFFFFFF, b=2, MUL_LAT=3, accept cycle 0 -> ready=0 in cycles 1-3; cycle 4: HI=0xFFFFFFFF, LO=0xFFFFFFFE, ready=1.
- MULTU same operands, then MFHI held valid during busy -> stall until cycle 4, accepted; res_valid in cycle 5 with res_data=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> at cycle 34 LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=0x0000000E, HI=0x00000002.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678 after 34 cycles. Signed 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO 0xCAFEBABE, then MFLO next cycle -> res_valid=1, res_data=0xCAFEBABE one cycle later. funct 0x1C accepted -> no change.
- DIV started with HI=LO=0x11111111, flush in cycle 10 -> busy=0 in cycle 11, HI/LO still 0x11111111. Separately: rst_n low in cycle 5 of a MUL -> all outputs at reset values immediately.
